tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the HDMI TMDS transmit path: takes 10-bit parallel words for one TMDS channel from the deserializer, finds word alignment by hunting for control tokens, and decodes each aligned word into 8-bit video data or a 2-bit control symbol plus a data-enable flag. One instance per colour channel sits between the DDR input deserializer and the pixel capture logic, all in the recovered pixel-clock domain.

## Interface
- LOCK_TOKENS, 8: consecutive control tokens required to declare lock.
- WINDOW, 2048: cycles without a control token before a slip (SEARCH) or lock loss (LOCKED); timer width is $clog2(WINDOW+1).
- pixclk  in  1  recovered pixel clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- raw  in  10  deserialized word, raw[0] received first; one new word every cycle.
- de  out  1  decoded word is video data.
- data  out  8  decoded video byte.
- ctrl  out  2  decoded control symbol {C1,C0}; on blue channel = {vSync,hSync}.
- locked  out  1  alignment locked.
- slip  out  4  current bit offset, 0..9.
- lock_loss_cnt  out  8  only with TMDS_DEC_STATS_EN.

## Operation
- Stage 1: raw_q <= raw, raw_qq <= raw_q. Window cat = {raw_q, raw_qq} (20 bits, raw_qq = bits 0..9); aligned[i] = cat[slip+i].
- Control tokens (aligned, MSB..LSB): 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11. Any other word is data.
- Data decode: d = aligned[9] ? ~aligned[7:0] : aligned[7:0]; out[0]=d[0]; out[i]= aligned[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), i=1..7.
- Stage 2 output regs, when locked (registered state LOCKED at the decode edge): token -> de=0, ctrl=symbol, data=0; data word -> de=1, data=decoded, ctrl holds. When not locked: de=0, data=0, ctrl=00.
- FSM states SEARCH, LOCKED. Counters: run (consecutive tokens), timer.
- SEARCH: token -> run+1, else run=0. timer+1 each cycle. run reaching LOCK_TOKENS -> LOCKED, timer=0. Else timer reaching WINDOW -> slip = (slip==9)?0:slip+1, run=0, timer=0.
- LOCKED: token -> timer=0; else timer+1. timer reaching WINDOW -> SEARCH, slip advances (wrap 9->0), run=0, timer=0.
- Simultaneous lock condition and timer expiry in SEARCH: lock wins, slip unchanged.
- Reset (any cycle, including mid-hunt or locked): state SEARCH, slip=0, run=0, timer=0, raw_q=raw_qq=0, de=0, data=0, ctrl=00, locked=0, lock_loss_cnt=0.

## Timing
- Latency: word whose final bit is presented on raw at edge N appears on de/data/ctrl after edge N+2.
- locked rises the cycle after the LOCK_TOKENS-th token is counted, falls the cycle after WINDOW expiry in LOCKED; slip updates same edge as the transition.
- After a slip change, run restarts from 0; words straddling the change are not trusted.
- No handshake: raw is sampled every cycle; outputs valid every cycle.

## Configuration
- TMDS_DEC_STATS_EN defined: lock_loss_cnt port present; increments on each LOCKED->SEARCH transition, saturates at 255, cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Aligned stream (slip 0): 160 tokens 1101010100 then data -> locked=1 after the 8th token (+1 cycle); ctrl=00, de=0 during blanking.
- Data decode, locked: raw=0x100 -> data=0x00, de=1; raw=0x200 -> data=0xFF, de=1, both 2 cycles after input.
- Stream delayed by 3 bits, blanking every 800 words: slip steps 0->1->2->3 after 2048-cycle windows, then locked=1 with slip=3; decoded bytes match transmitted sequence.
- Blue channel tokens cycling 00,01,10,11 -> ctrl follows each with 2-cycle latency; ctrl holds last symbol through active video.
- Remove tokens while locked (data only for 2048 cycles) -> locked=0, slip+1, lock_loss_cnt=1 (STATS build); slip 9 wraps to 0.
- Assert resetn=0 for one cycle while locked -> next cycle locked=0, slip=0, de=0, data=0, ctrl=00, lock_loss_cnt=0.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: word alignment hunt plus 10b/8b and control decode.
// Define TMDS_DEC_STATS_EN to add the saturating lock_loss_cnt output.
module tmds_channel_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int WINDOW      = 2048
) (
  input  logic       pixclk,
  input  logic       resetn,
  input  logic [9:0] raw,
  output logic       de,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] slip
`ifdef TMDS_DEC_STATS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int TW = $clog2(WINDOW + 1);
  localparam int RW = $clog2(LOCK_TOKENS + 1);

  localparam logic [TW-1:0] WIN   = TW'(WINDOW);
  localparam logic [RW-1:0] LOCKN = RW'(LOCK_TOKENS);

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t        state;
  logic [9:0]    raw_q;
  logic [9:0]    raw_qq;
  logic [19:0]   cat;
  logic [9:0]    aligned;
  logic          is_tok;
  logic [1:0]    sym;
  logic [7:0]    dq;
  logic [7:0]    dec;
  logic [RW-1:0] run;
  logic [RW-1:0] run_inc;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic [3:0]    slip_nxt;
  logic          lock_evt;
  logic          expire_evt;
  logic          loss_evt;

  // Two-word history so any 10-bit window inside it can be picked.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      raw_q  <= '0;
      raw_qq <= '0;
    end else begin
      raw_q  <= raw;
      raw_qq <= raw_q;
    end
  end

  assign cat     = {raw_q, raw_qq};
  assign aligned = cat[{1'b0, slip} +: 10];

  // Recognise the four control tokens.
  always_comb begin
    is_tok = 1'b1;
    sym    = 2'b00;
    unique case (1'b1)
      (aligned == TOK0): sym = 2'b00;
      (aligned == TOK1): sym = 2'b01;
      (aligned == TOK2): sym = 2'b10;
      (aligned == TOK3): sym = 2'b11;
      default:           is_tok = 1'b0;
    endcase
  end

  // Undo optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    dq     = aligned[9] ? ~aligned[7:0] : aligned[7:0];
    dec    = '0;
    dec[0] = dq[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = aligned[8] ? (dq[i] ^ dq[i-1])
                          : ~(dq[i] ^ dq[i-1]);
    end
  end

  assign run_inc   = run + 1'b1;
  assign timer_inc = timer + 1'b1;
  assign slip_nxt  = (slip == 4'd9) ? 4'd0 : slip + 4'd1;

  assign lock_evt   = (state == SEARCH) && is_tok &&
                      (run_inc == LOCKN);
  assign expire_evt = (timer_inc == WIN);
  assign loss_evt   = (state == LOCKED) && !is_tok &&
                      expire_evt;

  // Alignment hunt: slide the window until tokens repeat, then track.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      state  <= SEARCH;
      locked <= 1'b0;
      slip   <= '0;
      run    <= '0;
      timer  <= '0;
    end else begin
      unique case (state)
        SEARCH: begin
          run   <= is_tok ? run_inc : '0;
          timer <= timer_inc;
          if (lock_evt) begin
            state  <= LOCKED;
            locked <= 1'b1;
            run    <= '0;
            timer  <= '0;
          end else if (expire_evt) begin
            slip  <= slip_nxt;
            run   <= '0;
            timer <= '0;
          end
        end
        LOCKED: begin
          timer <= is_tok ? '0 : timer_inc;
          if (loss_evt) begin
            state  <= SEARCH;
            locked <= 1'b0;
            slip   <= slip_nxt;
            run    <= '0;
            timer  <= '0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Registered decode outputs; quiet until alignment is locked.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      de   <= 1'b0;
      data <= '0;
      ctrl <= '0;
    end else if (state == LOCKED) begin
      if (is_tok) begin
        de   <= 1'b0;
        data <= '0;
        ctrl <= sym;
      end else begin
        de   <= 1'b1;
        data <= dec;
      end
    end else begin
      de   <= 1'b0;
      data <= '0;
      ctrl <= '0;
    end
  end

`ifdef TMDS_DEC_STATS_EN
  // Count lock losses, saturating at 255.
  always_ff @(posedge pixclk) begin
    if (!resetn) begin
      lock_loss_cnt <= '0;
    end else if (loss_evt && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: serial-stream model plus scoreboard.
// Build with TMDS_DEC_STATS_EN to also check lock_loss_cnt.
module tb_tmds_channel_decoder;

  localparam int LOCK_TOKENS = 8;
  localparam int WINDOW      = 2048;

  logic       pixclk;
  logic       resetn;
  logic [9:0] raw;
  logic       de;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] slip;
`ifdef TMDS_DEC_STATS_EN
  logic [7:0] lock_loss_cnt;
`endif

  tmds_channel_decoder #(
    .LOCK_TOKENS(LOCK_TOKENS),
    .WINDOW(WINDOW)
  ) dut (
    .pixclk(pixclk),
    .resetn(resetn),
    .raw(raw),
    .de(de),
    .data(data),
    .ctrl(ctrl),
    .locked(locked),
    .slip(slip)
`ifdef TMDS_DEC_STATS_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  initial begin
    pixclk = 1'b1;
    forever #5 pixclk = ~pixclk;
  end

  typedef struct packed {
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] slip;
    logic [7:0] loss;
  } exp_t;

  exp_t eq[$];
  int   total = 0;
  int   bad   = 0;

  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011,
                          10'b0101010100, 10'b1010101011};

  // model state
  bit       m_lk;
  int       m_slip, m_run, m_timer, m_loss;
  bit       m_de;
  bit [7:0] m_data;
  bit [1:0] m_ctrl;
  bit       sb[$];
  bit       tx[$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic int tok_sym(logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == tok[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] dec8(logic [9:0] w);
    logic [7:0] q;
    q = w[9] ? ~w[7:0] : w[7:0];
    return q ^ {q[6:0], 1'b0} ^ (w[8] ? 8'h00 : 8'hFE);
  endfunction

  function automatic logic [9:0] enc(logic [7:0] d, bit xn, bit inv);
    logic [8:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  function automatic logic [9:0] rnd_data();
    logic [9:0] w;
    do begin
      w = enc(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end while (tok_sym(w) >= 0);
    return w;
  endfunction

  // Reference: window taken from the serial bit history at the current
  // offset, outputs from the pre-edge lock flag, then the hunt rules.
  task automatic model_step(input logic [9:0] w, input logic rn);
    logic [9:0] a;
    int         s;
    exp_t       e;
    if (!rn) begin
      m_lk = 0; m_slip = 0; m_run = 0; m_timer = 0; m_loss = 0;
      m_de = 0; m_data = 0; m_ctrl = 0;
      sb.delete();
      repeat (20) sb.push_back(1'b0);
    end else begin
      for (int i = 0; i < 10; i++) a[i] = sb[m_slip + i];
      s = tok_sym(a);
      if (m_lk) begin
        if (s >= 0) begin
          m_de = 0; m_ctrl = 2'(s); m_data = 0;
        end else begin
          m_de = 1; m_data = dec8(a);
        end
      end else begin
        m_de = 0; m_data = 0; m_ctrl = 0;
      end
      if (!m_lk) begin
        m_run = (s >= 0) ? m_run + 1 : 0;
        m_timer++;
        if (m_run == LOCK_TOKENS) begin
          m_lk = 1; m_run = 0; m_timer = 0;
        end else if (m_timer == WINDOW) begin
          m_slip = (m_slip + 1) % 10; m_run = 0; m_timer = 0;
        end
      end else begin
        m_timer = (s >= 0) ? 0 : m_timer + 1;
        if (m_timer == WINDOW) begin
          m_lk = 0; m_slip = (m_slip + 1) % 10;
          m_run = 0; m_timer = 0;
          if (m_loss < 255) m_loss++;
        end
      end
      for (int i = 0; i < 10; i++) begin
        sb.push_back(w[i]);
        void'(sb.pop_front());
      end
    end
    e.de     = m_de;
    e.data   = m_data;
    e.ctrl   = m_ctrl;
    e.locked = m_lk;
    e.slip   = 4'(m_slip);
`ifdef TMDS_DEC_STATS_EN
    e.loss   = 8'(m_loss);
`else
    e.loss   = 8'h00;
`endif
    eq.push_back(e);
  endtask

  task automatic drive(input logic [9:0] w, input logic rn);
    @(negedge pixclk);
    raw    = w;
    resetn = rn;
    model_step(w, rn);
  endtask

  // serialise a word through the transmit bit queue (may carry an offset)
  task automatic send(input logic [9:0] w);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) tx.push_back(w[i]);
    for (int i = 0; i < 10; i++) r[i] = tx.pop_front();
    drive(r, 1'b1);
  endtask

  task automatic do_reset(input int n);
    tx.delete();
    repeat (n) drive(10'h000, 1'b0);
  endtask

  // monitor
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge pixclk);
      #1;
      if (eq.size() > 0) begin
        e        = eq.pop_front();
        g.de     = de;
        g.data   = data;
        g.ctrl   = ctrl;
        g.locked = locked;
        g.slip   = slip;
`ifdef TMDS_DEC_STATS_EN
        g.loss   = lock_loss_cnt;
`else
        g.loss   = 8'h00;
`endif
        chk("cycle", 32'(g), 32'(e));
      end
    end
  end

  initial begin
    resetn = 1'b0;
    raw    = '0;
    sb.delete();
    repeat (20) sb.push_back(1'b0);

    do_reset(3);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_slip", 32'(slip), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);

    repeat (160) send(tok[0]);
    chk("p1_locked", 32'(locked), 32'd1);
    chk("p1_slip", 32'(slip), 32'd0);
    chk("p1_ctrl", 32'(ctrl), 32'd0);
    chk("p1_de", 32'(de), 32'd0);
    repeat (20) send(rnd_data());

    send(10'h100);
    send(10'h200);
    send(tok[1]);
    send(tok[1]);
    chk("dec100_data", 32'(data), 32'h00);
    chk("dec100_de", 32'(de), 32'd1);
    send(tok[1]);
    chk("dec200_data", 32'(data), 32'hFF);
    chk("dec200_de", 32'(de), 32'd1);

    for (int r = 0; r < 4; r++) begin
      repeat (12) send(tok[r]);
      chk("tok_ctrl", 32'(ctrl), 32'(r));
      chk("tok_de", 32'(de), 32'd0);
    end
    repeat (30) send(rnd_data());
    chk("hold_ctrl", 32'(ctrl), 32'd3);
    chk("hold_de", 32'(de), 32'd1);

    repeat (2100) send(rnd_data());
    chk("loss_locked", 32'(locked), 32'd0);
    chk("loss_slip", 32'(slip), 32'd1);
`ifdef TMDS_DEC_STATS_EN
    chk("loss_cnt", 32'(lock_loss_cnt), 32'd1);
`endif
    repeat (9 * WINDOW) send(rnd_data());
    chk("wrap_slip", 32'(slip), 32'd0);
    chk("wrap_locked", 32'(locked), 32'd0);

    do_reset(2);
    repeat (3) tx.push_back(1'b0);
    for (int k = 0; k < 7000; k++) begin
      if (k % 800 < 12) send(tok[0]);
      else send(rnd_data());
    end
    chk("off3_locked", 32'(locked), 32'd1);
    chk("off3_slip", 32'(slip), 32'd3);

    drive(10'h000, 1'b0);
    send(tok[0]);
    chk("rl_locked", 32'(locked), 32'd0);
    chk("rl_slip", 32'(slip), 32'd0);
    chk("rl_de", 32'(de), 32'd0);
    chk("rl_data", 32'(data), 32'd0);
    chk("rl_ctrl", 32'(ctrl), 32'd0);
`ifdef TMDS_DEC_STATS_EN
    chk("rl_cnt", 32'(lock_loss_cnt), 32'd0);
`endif

    repeat (3) send(tok[0]);
    @(posedge pixclk);
    #2;
    chk("sb_drain", 32'(eq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
